// File: rtl/demux_req_arbiter_pkg.sv
// ============================================================================
// Module  : demux_arb_pkg
// Brief   : Shared types and helpers for the demux request arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package demux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        SCAN  = 2'd2
    } state_t;

    localparam int MIN_HOLD = 1;

    // Width of an index into n items. A single-item range still needs one bit.
    function automatic int clog2_nz(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/demux_rr_pick.sv
// ============================================================================
// Module  : demux_rr_pick
// Brief   : Combinational round-robin picker. It searches upward from rr_ptr
//           and wraps around to find the first valid requester.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_rr_pick
    import demux_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = clog2_nz(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any_valid
);

    logic [IDX_W:0] w_sum;

    always_comb begin
        grant     = '0;
        idx       = '0;
        any_valid = 1'b0;
        w_sum     = '0;
        for (int k = 0; k < N; k++) begin
            // Candidate position (rr_ptr + k) mod N. rr_ptr is always below N.
            w_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(N)) begin
                w_sum = w_sum - (IDX_W+1)'(N);
            end
            if (!any_valid && valid[w_sum[IDX_W-1:0]]) begin
                any_valid                = 1'b1;
                idx                      = w_sum[IDX_W-1:0];
                grant[w_sum[IDX_W-1:0]]  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/demux_req_arbiter.sv
// ============================================================================
// Module  : demux_req_arbiter
// Brief   : Round-robin sequencer that shares one registered demux tree among
//           NUM_REQ requesters. Each grant holds sel/in for HOLD_CYC cycles.
//           Define DEMUX_ARB_SCAN_EN to enable the idle output scan.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_req_arbiter
    import demux_arb_pkg::*;
#(
    parameter int SEL_W     = 9,
    parameter int NUM_REQ   = 4,
    parameter int HOLD_CYC  = 2,
    parameter int IDLE_SCAN = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*SEL_W-1:0]     req_sel,
    input  logic [NUM_REQ-1:0]           req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [SEL_W-1:0]             dmx_sel,
    output logic                         dmx_in,
    output logic                         dmx_vld,
    output logic [clog2_nz(NUM_REQ)-1:0] grant_id,
    output logic                         scan_active
);

    localparam int c_IDX_W  = clog2_nz(NUM_REQ);
    localparam int c_HOLD   = (HOLD_CYC < MIN_HOLD) ? MIN_HOLD : HOLD_CYC;
    localparam int c_HOLD_W = clog2_nz(c_HOLD);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(c_HOLD - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(NUM_REQ - 1);

    state_t               r_state, w_state_nxt;
    logic [c_IDX_W-1:0]   r_rr_ptr, w_rr_nxt;
    logic [c_HOLD_W-1:0]  r_hold_cnt, w_hold_nxt;
    logic [SEL_W-1:0]     r_dmx_sel, w_sel_nxt;
    logic                 r_dmx_in, w_in_nxt;
    logic                 r_dmx_vld, w_vld_nxt;
    logic [c_IDX_W-1:0]   r_grant_id, w_gid_nxt;

    logic [NUM_REQ-1:0]   w_grant;
    logic [c_IDX_W-1:0]   w_idx;
    logic                 w_any;
    logic [SEL_W-1:0]     w_win_sel;

`ifdef DEMUX_ARB_SCAN_EN
    localparam int c_IDLE   = (IDLE_SCAN < 1) ? 1 : IDLE_SCAN;
    localparam int c_IDLE_W = clog2_nz(c_IDLE);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(c_IDLE - 1);

    logic                 r_scan_active, w_scan_act_nxt;
    logic [SEL_W-1:0]     r_scan_ptr, w_scan_ptr_nxt;
    logic [c_IDLE_W-1:0]  r_idle_cnt, w_idle_nxt;
`endif

    demux_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (c_IDX_W)
    ) u_pick (
        .valid     (req_valid),
        .rr_ptr    (r_rr_ptr),
        .grant     (w_grant),
        .idx       (w_idx),
        .any_valid (w_any)
    );

    assign w_win_sel = req_sel[int'(w_idx)*SEL_W +: SEL_W];
    assign req_ready = (r_state == IDLE) ? w_grant : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_hold_nxt  = r_hold_cnt;
        w_sel_nxt   = r_dmx_sel;
        w_in_nxt    = r_dmx_in;
        w_vld_nxt   = r_dmx_vld;
        w_gid_nxt   = r_grant_id;
`ifdef DEMUX_ARB_SCAN_EN
        w_scan_act_nxt = r_scan_active;
        w_scan_ptr_nxt = r_scan_ptr;
        w_idle_nxt     = r_idle_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_sel_nxt   = w_win_sel;
                    w_in_nxt    = req_data[w_idx];
                    w_vld_nxt   = 1'b1;
                    w_gid_nxt   = w_idx;
                    w_rr_nxt    = (w_idx == c_IDX_LAST) ? '0 : w_idx + c_IDX_W'(1);
                    w_hold_nxt  = c_HOLD_LAST;
                    w_state_nxt = ISSUE;
`ifdef DEMUX_ARB_SCAN_EN
                    w_idle_nxt  = '0;
                end else if (r_idle_cnt == c_IDLE_LAST) begin
                    // First scan step is issued on the entry edge itself.
                    w_sel_nxt      = r_scan_ptr;
                    w_in_nxt       = 1'b1;
                    w_vld_nxt      = 1'b1;
                    w_scan_ptr_nxt = r_scan_ptr + SEL_W'(1);
                    w_scan_act_nxt = 1'b1;
                    w_idle_nxt     = '0;
                    w_state_nxt    = SCAN;
                end else begin
                    w_idle_nxt = r_idle_cnt + c_IDLE_W'(1);
`endif
                end
            end
            ISSUE: begin
                if (r_hold_cnt == '0) begin
                    w_in_nxt    = 1'b0;
                    w_vld_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end else begin
                    w_hold_nxt = r_hold_cnt - c_HOLD_W'(1);
                end
            end
`ifdef DEMUX_ARB_SCAN_EN
            SCAN: begin
                if (|req_valid) begin
                    // Let the step in flight finish; requests are served from IDLE.
                    w_in_nxt       = 1'b0;
                    w_vld_nxt      = 1'b0;
                    w_scan_act_nxt = 1'b0;
                    w_idle_nxt     = '0;
                    w_state_nxt    = IDLE;
                end else begin
                    w_sel_nxt      = r_scan_ptr;
                    w_scan_ptr_nxt = r_scan_ptr + SEL_W'(1);
                end
            end
`endif
            default: begin
                w_in_nxt    = 1'b0;
                w_vld_nxt   = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_hold_cnt <= '0;
            r_dmx_sel  <= '0;
            r_dmx_in   <= 1'b0;
            r_dmx_vld  <= 1'b0;
            r_grant_id <= '0;
`ifdef DEMUX_ARB_SCAN_EN
            r_scan_active <= 1'b0;
            r_scan_ptr    <= '0;
            r_idle_cnt    <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_dmx_sel  <= w_sel_nxt;
            r_dmx_in   <= w_in_nxt;
            r_dmx_vld  <= w_vld_nxt;
            r_grant_id <= w_gid_nxt;
`ifdef DEMUX_ARB_SCAN_EN
            r_scan_active <= w_scan_act_nxt;
            r_scan_ptr    <= w_scan_ptr_nxt;
            r_idle_cnt    <= w_idle_nxt;
`endif
        end
    end

    assign dmx_sel  = r_dmx_sel;
    assign dmx_in   = r_dmx_in;
    assign dmx_vld  = r_dmx_vld;
    assign grant_id = r_grant_id;

`ifdef DEMUX_ARB_SCAN_EN
    assign scan_active = r_scan_active;
`else
    assign scan_active = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux_req_arbiter.sv
// ============================================================================
// Module  : tb_demux_req_arbiter
// Brief   : Self-checking bench for demux_req_arbiter. Directed scenarios are
//           followed by a randomized phase, checked against a reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_req_arbiter;

    localparam int SEL_W     = 9;
    localparam int NUM_REQ   = 4;
    localparam int HOLD_CYC  = 2;
    localparam int IDLE_SCAN = 16;
    localparam int N_OUT     = 1 << SEL_W;
`ifdef DEMUX_ARB_SCAN_EN
    localparam bit SCAN_EN = 1'b1;
`else
    localparam bit SCAN_EN = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*SEL_W-1:0] req_sel;
    logic [NUM_REQ-1:0]       req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic [SEL_W-1:0]         dmx_sel;
    logic                     dmx_in;
    logic                     dmx_vld;
    logic [1:0]               grant_id;
    logic                     scan_active;

    always #5 clk = ~clk;

    demux_req_arbiter #(
        .SEL_W     (SEL_W),
        .NUM_REQ   (NUM_REQ),
        .HOLD_CYC  (HOLD_CYC),
        .IDLE_SCAN (IDLE_SCAN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_sel     (req_sel),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .dmx_sel     (dmx_sel),
        .dmx_in      (dmx_in),
        .dmx_vld     (dmx_vld),
        .grant_id    (grant_id),
        .scan_active (scan_active)
    );

    // Leaf register stage of the demux tree that this block drives.
    logic [N_OUT-1:0] tree_q = '0;
    always @(posedge clk) begin
        tree_q <= '0;
        if (dmx_in) tree_q[dmx_sel] <= 1'b1;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: transaction-level view of the shared tree.
    int m_rr, m_busy, m_sel, m_in, m_vld, m_gid, m_scan, m_sptr, m_idle;
    int ready_seen [NUM_REQ];
    int order_q [$];
    int prev_vld;
    int bound;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = 0; m_busy = 0; m_sel = 0; m_in = 0; m_vld = 0;
        m_gid = 0; m_scan = 0; m_sptr = 0; m_idle = 0;
    endtask

    function automatic int pick(input logic [NUM_REQ-1:0] v);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(m_rr + k) % NUM_REQ]) return (m_rr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // One clock: check ready, advance the model across the edge, check outputs.
    task automatic tick();
        int w;
        #1;
        w = (m_busy == 0 && m_scan == 0) ? pick(req_valid) : -1;
        chk("req_ready", {28'd0, req_ready}, (w >= 0) ? (32'd1 << w) : 32'd0);
        for (int i = 0; i < NUM_REQ; i++) ready_seen[i] += int'(req_ready[i]);
        if (m_scan != 0) begin
            if (req_valid != '0) begin
                m_scan = 0; m_in = 0; m_vld = 0; m_idle = 0;
            end else begin
                m_sel = m_sptr; m_sptr = (m_sptr + 1) % N_OUT;
            end
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin m_in = 0; m_vld = 0; end
        end else if (w >= 0) begin
            m_sel = int'(req_sel[w*SEL_W +: SEL_W]);
            m_in = int'(req_data[w]); m_vld = 1; m_gid = w;
            m_rr = (w + 1) % NUM_REQ; m_busy = HOLD_CYC; m_idle = 0;
        end else if (SCAN_EN) begin
            m_idle++;
            if (m_idle == IDLE_SCAN) begin
                m_scan = 1; m_sel = m_sptr; m_in = 1; m_vld = 1;
                m_sptr = (m_sptr + 1) % N_OUT; m_idle = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("dmx_sel", {23'd0, dmx_sel}, m_sel);
        chk("dmx_in", {31'd0, dmx_in}, m_in);
        chk("dmx_vld", {31'd0, dmx_vld}, m_vld);
        chk("grant_id", {30'd0, grant_id}, m_gid);
        chk("scan_active", {31'd0, scan_active}, m_scan);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dmx_sel", {23'd0, dmx_sel}, 0);
        chk("rst_dmx_in", {31'd0, dmx_in}, 0);
        chk("rst_grant_id", {30'd0, grant_id}, 0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req_valid = '0; req_sel = '0; req_data = '0;
        for (int i = 0; i < NUM_REQ; i++) ready_seen[i] = 0;
        do_reset();

        // Single request routed to output 421, pulse seen at the tree.
        req_valid = 4'b0001; req_sel[0 +: SEL_W] = 9'h1A5; req_data = 4'b0001;
        tick();
        req_valid = '0;
        chk("single_sel", {23'd0, dmx_sel}, 32'h1A5);
        tick();
        chk("tree421_c1", {31'd0, tree_q[421]}, 1);
        tick();
        chk("tree421_c2", {31'd0, tree_q[421]}, 1);
        chk("single_drop", {31'd0, dmx_in}, 0);
        tick();
        chk("tree421_c3", {31'd0, tree_q[421]}, 0);

        // Asynchronous reset in the middle of a grant.
        req_valid = 4'b0100; req_sel[2*SEL_W +: SEL_W] = 9'h0F3; req_data = 4'b0100;
        tick();
        chk("pre_rst_in", {31'd0, dmx_in}, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_in", {31'd0, dmx_in}, 0);
        chk("async_rst_vld", {31'd0, dmx_vld}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        req_valid = 4'b1111; req_sel = {9'd3, 9'd2, 9'd1, 9'd0}; req_data = 4'b1010;
        #1;
        chk("rr_after_rst", {28'd0, req_ready}, 32'h1);

        // All requesters valid: fair order 0,1,2,3,0.
        for (int i = 0; i < NUM_REQ; i++) ready_seen[i] = 0;
        prev_vld = 0;
        for (int t = 0; t < 15; t++) begin
            tick();
            if (dmx_vld && prev_vld == 0) order_q.push_back(int'(grant_id));
            prev_vld = int'(dmx_vld);
            if (t == 11) begin
                for (int i = 0; i < NUM_REQ; i++) chk("ready_once", ready_seen[i], 1);
            end
        end
        chk("order_len", order_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk("order", (i < order_q.size()) ? order_q[i] : -1, i % NUM_REQ);
        end

        // Back-to-back grants to requester 1: one-cycle gap between them.
        req_valid = 4'b0010;
        for (int t = 0; t < 6; t++) begin
            tick();
            chk("b2b_in", {31'd0, dmx_in}, (t % 3 == 2) ? 0 : 1);
        end
        req_valid = '0;
        tick(); tick();

`ifdef DEMUX_ARB_SCAN_EN
        do_reset();
        for (int t = 0; t < IDLE_SCAN; t++) tick();
        chk("scan_start", {31'd0, scan_active}, 1);
        chk("scan_step0", {23'd0, dmx_sel}, 0);
        for (int t = 1; t <= 5; t++) begin
            tick();
            chk("scan_step", {23'd0, dmx_sel}, t);
        end
        req_valid = 4'b0100; req_sel[2*SEL_W +: SEL_W] = 9'h055;
        tick();
        chk("scan_stop", {31'd0, scan_active}, 0);
        tick();
        chk("scan_grant", {30'd0, grant_id}, 2);
        req_valid = '0;
        bound = 0;
        while (!scan_active && bound < 40) begin tick(); bound++; end
        chk("scan_resume", {23'd0, dmx_sel}, 6);
        bound = 0;
        while (dmx_sel != '1 && bound < 600) begin tick(); bound++; end
        tick();
        chk("scan_wrap", {23'd0, dmx_sel}, 0);
        req_valid = 4'b0001;
        tick(); tick();
        req_valid = '0;
        repeat (HOLD_CYC + 1) tick();
`else
        for (int t = 0; t < 100; t++) tick();
        chk("no_scan", {31'd0, scan_active}, 0);
`endif

        // Randomized traffic with occasional idle stretches.
        for (int t = 0; t < 800; t++) begin
            if ((t % 200) < 20) req_valid = '0;
            else req_valid = ($urandom_range(0, 3) == 0) ? '0 : NUM_REQ'($urandom);
            req_sel  = {NUM_REQ*SEL_W{1'b0}} | {$urandom, $urandom};
            req_data = NUM_REQ'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
